regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation pipelined core.
- Sits between decode (read and issue) and writeback; replaces the single-write, two-read file.
- Adds configurable read/write port counts, an optional same-cycle write-to-read bypass, and a per-register pending scoreboard that decode uses for RAW hazard stalls.
- Register 0 is hardwired zero. The stack-pointer register is seeded on reset.

Parameters:
- DWIDTH, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥ 2).
- AW, $clog2(NREGS), address width (derived, not overridable).
- NRD, 2, number of combinational read ports (1..4).
- NWR, 2, number of write ports (1..3).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- SP_IDX, 2, register seeded on reset.
- SP_INIT, 32'h4000_0002, reset value of register SP_IDX.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- rs_addr_i  in  NRD x AW  read addresses.
- rs_data_o  out  NRD x DWIDTH  read data.
- rs_busy_o  out  NRD  pending flag of each read address.
- wr_en_i  in  NWR  write enables.
- wr_addr_i  in  NWR x AW  write addresses.
- wr_data_i  in  NWR x DWIDTH  write data.
- iss_en_i  in  1  an instruction with a destination issues this cycle.
- iss_rd_i  in  AW  destination of the issuing instruction.
- busy_o  out  NREGS  full scoreboard vector; bit 0 is always 0.
- wr_conflict_o  out  1  registered; pulses 1 cycle after two or more enabled write ports target the same non-zero address.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low: assertion takes effect immediately; deassertion is synchronous to clk_i.
- Reset values:
  - All registers are 0, except reg[SP_IDX] = SP_INIT.
  - busy = 0; wr_conflict_o = 0.
  - rs_data_o and rs_busy_o follow the reset state combinationally.
  - Reset asserted mid-operation discards all pending writes and issues that cycle.
- Reads:
  - Purely combinational, zero latency.
  - Address 0 returns 0 and busy = 0 regardless of other state.
- Read bypass, BYPASS = 1:
  - If an enabled write port targets the read address (non-zero) this cycle, rs_data_o returns that port's wr_data_i.
  - rs_busy_o returns 0 for that address.
- Read bypass, BYPASS = 0:
  - rs_data_o returns the stored value.
  - rs_busy_o returns the current busy bit.
- Writes:
  - Committed at the rising edge when wr_en_i[k] = 1 and wr_addr_i[k] != 0.
  - Writes to address 0 are ignored and do not raise wr_conflict_o.
- Write priority:
  - When multiple ports hit the same address, the highest-indexed port wins, for both storage and bypass.
  - wr_conflict_o is set for one cycle after such a clash.
- Scoreboard, next-state per register r:
  - Any enabled write to r clears busy[r].
  - iss_en_i with iss_rd_i == r (r ≠ 0) sets busy[r].
  - When both happen in the same cycle, set wins: the newer producer is still outstanding.
  - iss_rd_i == 0 has no effect.
  - A write to a register that is not busy is legal and stores normally.
- Widths:
  - No arithmetic.
  - Addresses ≥ NREGS cannot occur, because NREGS is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - the default DWIDTH/NREGS/SP_IDX/SP_INIT localparams;
  - typedef reg_addr_t, logic [AW-1:0];
  - typedef reg_data_t.
- One sub-module, regfile_wr_arb: for a given address it returns hit, winning data, and multi-hit.
  - Instantiated per read port for the bypass.
  - Instantiated per register for the write decode and scoreboard clear.

Test Plan:
- Reset check: assert reset_ni = 0 asynchronously mid-cycle, then read all addresses → rs_data_o = 0, except addr 2 = 32'h4000_0002; busy_o = 0.
- Basic write and x0 protection: write port 0 writes 5 ← 32'hDEAD_BEEF and port 1 writes 0 ← 32'h1234 → next cycle addr 5 reads 32'hDEAD_BEEF, addr 0 reads 0, wr_conflict_o = 0.
- Write collision: ports 0 and 1 both write addr 7, data 32'h1111 and 32'h2222 → bypass read of addr 7 that cycle = 32'h2222 (BYPASS = 1); stored value = 32'h2222; wr_conflict_o = 1 for exactly one cycle.
- Scoreboard set/clear: issue rd = 9, then 3 idle cycles → rs_busy_o = 1 for addr 9; write 9 ← 32'h55 → same-cycle rs_busy_o = 0 and data = 32'h55; busy_o[9] = 0 afterwards.
- Simultaneous issue and write: issue rd = 9 while port 1 writes 9 ← 32'hAA → busy_o[9] = 1 next cycle and reg 9 = 32'hAA.
- BYPASS = 0 build: write 4 ← 32'h77 while reading 4 → same cycle returns the old value 0; next cycle returns 32'h77.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file
package regfile_pkg;
    localparam int DWIDTH_DEF = 32;
    localparam int NREGS_DEF  = 32;
    localparam int AW_DEF     = $clog2(NREGS_DEF);
    localparam int SP_IDX_DEF = 2;
    localparam logic [DWIDTH_DEF-1:0] SP_INIT_DEF = 32'h4000_0002;
    typedef logic [AW_DEF-1:0]     reg_addr_t;
    typedef logic [DWIDTH_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: resolves all write ports against one address (highest port wins)
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AW     = AW_DEF,
    parameter int NWR    = 2
) (
    input  logic [AW-1:0]              addr_i,
    input  logic [NWR-1:0]             wr_en_i,
    input  logic [NWR-1:0][AW-1:0]     wr_addr_i,
    input  logic [NWR-1:0][DWIDTH-1:0] wr_data_i,
    output logic                       hit_o,
    output logic [DWIDTH-1:0]          data_o,
    output logic                       multi_o
);
    // Ascending scan so a later (higher) port overrides; address 0 never hits
    always_comb begin
        hit_o   = 1'b0;
        data_o  = '0;
        multi_o = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en_i[k] && wr_addr_i[k] == addr_i && addr_i != '0) begin
                multi_o = multi_o | hit_o;
                hit_o   = 1'b1;
                data_o  = wr_data_i[k];
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional write bypass and pending scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DWIDTH  = DWIDTH_DEF,
    parameter int                NREGS   = NREGS_DEF,
    parameter int                NRD     = 2,
    parameter int                NWR     = 2,
    parameter int                BYPASS  = 1,
    parameter int                SP_IDX  = SP_IDX_DEF,
    parameter logic [DWIDTH-1:0] SP_INIT = SP_INIT_DEF,
    localparam int               AW      = $clog2(NREGS)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NRD-1:0][AW-1:0]     rs_addr_i,
    output logic [NRD-1:0][DWIDTH-1:0] rs_data_o,
    output logic [NRD-1:0]             rs_busy_o,
    input  logic [NWR-1:0]             wr_en_i,
    input  logic [NWR-1:0][AW-1:0]     wr_addr_i,
    input  logic [NWR-1:0][DWIDTH-1:0] wr_data_i,
    input  logic                       iss_en_i,
    input  logic [AW-1:0]              iss_rd_i,
    output logic [NREGS-1:0]           busy_o,
    output logic                       wr_conflict_o
);
    logic [DWIDTH-1:0] regs_q [NREGS];
    logic [DWIDTH-1:0] regs_d [NREGS];
    logic [DWIDTH-1:0] wdata_w [NREGS];
    logic [NREGS-1:0]  hit_w;
    logic [NREGS-1:0]  multi_w;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              conflict_q;
    logic              conflict_d;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        regfile_wr_arb #(.DWIDTH(DWIDTH), .AW(AW), .NWR(NWR)) u_arb (
            .addr_i   (AW'(r)),
            .wr_en_i  (wr_en_i),
            .wr_addr_i(wr_addr_i),
            .wr_data_i(wr_data_i),
            .hit_o    (hit_w[r]),
            .data_o   (wdata_w[r]),
            .multi_o  (multi_w[r])
        );
    end

    // Next state: winning write data, scoreboard with issue-over-writeback priority
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = hit_w[r] ? wdata_w[r] : regs_q[r];
            busy_d[r] = (r != 0) && ((iss_en_i && iss_rd_i == AW'(r)) || (busy_q[r] && !hit_w[r]));
        end
        conflict_d = |multi_w;
    end

    // State registers; the stack pointer is seeded on reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_o        = busy_q;
    assign wr_conflict_o = conflict_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic              hit;
        logic [DWIDTH-1:0] bdata;
        if (BYPASS != 0) begin : g_byp
            logic multi_unused;
            regfile_wr_arb #(.DWIDTH(DWIDTH), .AW(AW), .NWR(NWR)) u_arb (
                .addr_i   (rs_addr_i[i]),
                .wr_en_i  (wr_en_i),
                .wr_addr_i(wr_addr_i),
                .wr_data_i(wr_data_i),
                .hit_o    (hit),
                .data_o   (bdata),
                .multi_o  (multi_unused)
            );
        end else begin : g_nobyp
            assign hit   = 1'b0;
            assign bdata = '0;
        end
        assign rs_data_o[i] = (rs_addr_i[i] == '0) ? '0 : hit ? bdata : regs_q[rs_addr_i[i]];
        assign rs_busy_o[i] = !hit && busy_q[rs_addr_i[i]];
    end
endmodule
